// File: rtl/jump_ctrl.sv
// Jump game controller: debounces the player key, charges a jump length while held,
// hands the jump to the jump block, then judges the landing and keeps score.
module jump_ctrl #(
    parameter int CHARGE_STEP = 2,
    parameter int MAX_LEN     = 400,
    parameter int DEBOUNCE    = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pulse_i,
    input  logic       key_i,
    input  logic       jump_fin_i,
    input  logic [9:0] man_x_i,
    input  logic [9:0] plat_x_i,
    input  logic [9:0] plat_w_i,
    output logic       jump_en_o,
    output logic [9:0] length_o,
    output logic       generate_en_o,
    output logic [7:0] score_o,
    output logic       game_over_o,
    output logic [2:0] state_o
);

    localparam int DB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHARGE = 3'd1,
        ST_JUMP   = 3'd2,
        ST_JUDGE  = 3'd3,
        ST_NEXT   = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    // Charge step with saturation; the 11-bit sum keeps the compare wrap-free.
    function automatic logic [9:0] len_step(input logic [9:0] len);
        logic [10:0] sum;
        sum = {1'b0, len} + 11'(CHARGE_STEP);
        if (sum > 11'(MAX_LEN)) begin
            len_step = 10'(MAX_LEN);
        end else begin
            len_step = sum[9:0];
        end
    endfunction

    function automatic logic [7:0] score_inc(input logic [7:0] sc);
        if (sc == 8'd255) begin
            score_inc = 8'd255;
        end else begin
            score_inc = sc + 8'd1;
        end
    endfunction

    logic            key_meta_q;
    logic            key_s_q;
    logic            key_db_q;
    logic            key_db_d;
    logic            key_db_dly_q;
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            key_rise_s;
    logic            key_fall_s;

    state_t          state_q;
    state_t          state_d;
    logic            jump_en_q;
    logic            jump_en_d;
    logic [9:0]      length_q;
    logic [9:0]      length_d;
    logic            gen_q;
    logic            gen_d;
    logic [7:0]      score_q;
    logic [7:0]      score_d;
    logic            game_over_q;
    logic            game_over_d;
    logic [9:0]      land_x_q;
    logic [9:0]      land_x_d;
    logic [10:0]     plat_end_s;
    logic            hit_s;

    // Two-flop synchroniser for the asynchronous key.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_meta_q <= 1'b0;
            key_s_q    <= 1'b0;
        end else begin
            key_meta_q <= key_i;
            key_s_q    <= key_meta_q;
        end
    end

    // Debounce next-state: a mismatch must persist for DEBOUNCE frame ticks.
    always_comb begin
        db_cnt_d = db_cnt_q;
        key_db_d = key_db_q;
        if (pulse_i) begin
            if (key_s_q == key_db_q) begin
                db_cnt_d = {DB_W{1'b0}};
            end else if (db_cnt_q == DB_W'(DEBOUNCE - 1)) begin
                key_db_d = ~key_db_q;
                db_cnt_d = {DB_W{1'b0}};
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end else begin
            db_cnt_d = db_cnt_q;
        end
    end

    // Debounce state and delayed copy for edge strobes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_cnt_q     <= {DB_W{1'b0}};
            key_db_q     <= 1'b0;
            key_db_dly_q <= 1'b0;
        end else begin
            db_cnt_q     <= db_cnt_d;
            key_db_q     <= key_db_d;
            key_db_dly_q <= key_db_q;
        end
    end

    assign key_rise_s = key_db_q & ~key_db_dly_q;
    assign key_fall_s = ~key_db_q & key_db_dly_q;

    assign plat_end_s = {1'b0, plat_x_i} + {1'b0, plat_w_i};
    assign hit_s      = ({1'b0, land_x_q} >= {1'b0, plat_x_i}) &&
                        ({1'b0, land_x_q} <= plat_end_s);

    // Game FSM next-state and registered-output next values.
    always_comb begin
        state_d     = state_q;
        jump_en_d   = jump_en_q;
        length_d    = length_q;
        gen_d       = 1'b0;
        score_d     = score_q;
        game_over_d = game_over_q;
        land_x_d    = land_x_q;
        case (state_q)
            ST_IDLE: begin
                length_d  = 10'd0;
                jump_en_d = 1'b0;
                if (key_rise_s) begin
                    state_d = ST_CHARGE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHARGE: begin
                if (pulse_i) begin
                    length_d = len_step(length_q);
                end else begin
                    length_d = length_q;
                end
                if (key_fall_s) begin
                    jump_en_d = 1'b1;
                    state_d   = ST_JUMP;
                end else begin
                    state_d   = ST_CHARGE;
                end
            end
            ST_JUMP: begin
                if (jump_fin_i) begin
                    land_x_d  = man_x_i;
                    jump_en_d = 1'b0;
                    state_d   = ST_JUDGE;
                end else begin
                    state_d   = ST_JUMP;
                end
            end
            ST_JUDGE: begin
                if (hit_s) begin
                    score_d = score_inc(score_q);
                    gen_d   = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end
            end
            ST_NEXT: begin
                length_d = 10'd0;
                state_d  = ST_IDLE;
            end
            ST_OVER: begin
                jump_en_d = 1'b0;
                if (key_rise_s) begin
                    score_d     = 8'd0;
                    gen_d       = 1'b1;
                    game_over_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    game_over_d = 1'b1;
                    state_d     = ST_OVER;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                jump_en_d   = 1'b0;
                length_d    = 10'd0;
                game_over_d = 1'b0;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            jump_en_q   <= 1'b0;
            length_q    <= 10'd0;
            gen_q       <= 1'b0;
            score_q     <= 8'd0;
            game_over_q <= 1'b0;
            land_x_q    <= 10'd0;
        end else begin
            state_q     <= state_d;
            jump_en_q   <= jump_en_d;
            length_q    <= length_d;
            gen_q       <= gen_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            land_x_q    <= land_x_d;
        end
    end

    assign jump_en_o     = jump_en_q;
    assign length_o      = length_q;
    assign generate_en_o = gen_q;
    assign score_o       = score_q;
    assign game_over_o   = game_over_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl: stimulus queues expected events, a negedge monitor
// pops and compares them when the DUT raises jump_en, generate_en or game_over.
module tb_jump_ctrl;

    logic       clk;
    logic       rst_ni;
    logic       pulse;
    logic       key;
    logic       jump_fin;
    logic [9:0] man_x;
    logic [9:0] plat_x;
    logic [9:0] plat_w;
    logic       jump_en;
    logic [9:0] length;
    logic       gen;
    logic [7:0] score;
    logic       game_over;
    logic [2:0] state;

    typedef struct {
        int kind;   // 0 jump start, 1 generate, 2 game over
        int len;
        int score;
        int go;
        int cyc;    // -1 means timing not checked
    } exp_t;

    exp_t q[$];
    int   n_vec;
    int   n_miss;
    int   cyc;
    int   exp_score;
    logic jump_en_prev;
    logic go_prev;

    jump_ctrl dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .pulse_i      (pulse),
        .key_i        (key),
        .jump_fin_i   (jump_fin),
        .man_x_i      (man_x),
        .plat_x_i     (plat_x),
        .plat_w_i     (plat_w),
        .jump_en_o    (jump_en),
        .length_o     (length),
        .generate_en_o(gen),
        .score_o      (score),
        .game_over_o  (game_over),
        .state_o      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int kind, input int len, input int sc, input int go, input int c);
        exp_t e;
        e.kind  = kind;
        e.len   = len;
        e.score = sc;
        e.go    = go;
        e.cyc   = c;
        q.push_back(e);
    endtask

    task automatic handle(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            check("unexpected_event", kind, -1);
        end else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            case (kind)
                0: check("jump_len", int'(length), e.len);
                1: begin
                    check("gen_score", int'(score), e.score);
                    check("gen_game_over", int'(game_over), 0);
                    check("gen_no_jump_en", int'(jump_en), 0);
                    if (e.cyc >= 0) check("gen_latency", cyc, e.cyc);
                end
                default: begin
                    check("over_score", int'(score), e.score);
                    check("over_jump_en", int'(jump_en), 0);
                    check("over_latency", cyc, e.cyc);
                end
            endcase
        end
    endtask

    // Output monitor
    always @(negedge clk) begin
        if (rst_ni) begin
            if (jump_en && !jump_en_prev) handle(0);
            if (gen) handle(1);
            if (game_over && !go_prev) handle(2);
        end
        jump_en_prev <= jump_en;
        go_prev      <= game_over;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_pulse();
        pulse = 1'b1;
        tick();
        pulse = 1'b0;
        repeat (3) tick();
    endtask

    // Hold the key n frame ticks, release for 3 ticks; ends in JUMP.
    task automatic jump_round(input int n, input int exp_len);
        key = 1'b1;
        repeat (2) tick();
        repeat (n) do_pulse();
        push_exp(0, exp_len, 0, 0, -1);
        key = 1'b0;
        repeat (2) tick();
        repeat (3) do_pulse();
        check("in_jump_state", int'(state), 2);
    endtask

    task automatic land(input int mx, input bit exp_hit);
        int t0;
        man_x    = 10'(mx);
        jump_fin = 1'b1;
        t0       = cyc;
        if (exp_hit) begin
            exp_score = (exp_score < 255) ? exp_score + 1 : 255;
            push_exp(1, 0, exp_score, 0, t0 + 2);
        end else begin
            push_exp(2, 0, exp_score, 1, t0 + 2);
        end
        tick();
        jump_fin = 1'b0;
        repeat (4) tick();
    endtask

    task automatic restart_from_over();
        push_exp(1, 0, 0, 0, -1);
        exp_score = 0;
        key = 1'b1;
        repeat (2) tick();
        repeat (3) do_pulse();
        key = 1'b0;
        repeat (2) tick();
        repeat (3) do_pulse();
        check("restart_idle", int'(state), 0);
        check("restart_score", int'(score), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_jump_en"}, int'(jump_en), 0);
        check({tag, "_length"}, int'(length), 0);
        check({tag, "_gen"}, int'(gen), 0);
        check({tag, "_score"}, int'(score), 0);
        check({tag, "_game_over"}, int'(game_over), 0);
    endtask

    initial begin
        n_vec = 0; n_miss = 0; cyc = 0; exp_score = 0;
        jump_en_prev = 1'b0; go_prev = 1'b0;
        rst_ni = 1'b1; pulse = 1'b0; key = 1'b0; jump_fin = 1'b0;
        man_x = 10'd0; plat_x = 10'd200; plat_w = 10'd40;
        #1 rst_ni = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (2) tick();

        // stray jump_fin in IDLE
        man_x = 10'd220; jump_fin = 1'b1;
        tick();
        jump_fin = 1'b0;
        repeat (3) tick();
        check("fin_idle_state", int'(state), 0);
        check("fin_idle_score", int'(score), 0);

        // 10-pulse hold, then key toggling during JUMP
        jump_round(10, 20);
        key = 1'b1;
        repeat (2) tick();
        repeat (4) do_pulse();
        check("jump_toggle_state", int'(state), 2);
        check("jump_toggle_len", int'(length), 20);
        key = 1'b0;
        repeat (2) tick();
        repeat (4) do_pulse();
        check("jump_release_state", int'(state), 2);
        check("jump_release_len", int'(length), 20);
        land(200, 1'b1);
        check("after_next_len", int'(length), 0);

        jump_round(4, 8);
        land(240, 1'b1);

        // 1- and 2-pulse key glitches in IDLE
        for (int g = 1; g <= 2; g++) begin
            key = 1'b1;
            repeat (2) tick();
            repeat (g) do_pulse();
            key = 1'b0;
            repeat (2) tick();
            repeat (3) do_pulse();
            check("glitch_state", int'(state), 0);
            check("glitch_len", int'(length), 0);
        end

        // saturation, then a miss just past the platform edge
        jump_round(300, 400);
        repeat (5) tick();
        check("sat_len_held", int'(length), 400);
        land(241, 1'b0);
        check("over_flag", int'(game_over), 1);
        check("over_state", int'(state), 5);
        restart_from_over();

        // platform end beyond 10 bits must not wrap
        plat_x = 10'd1000; plat_w = 10'd40;
        jump_round(3, 6);
        land(1023, 1'b1);
        plat_x = 10'd200; plat_w = 10'd40;
        jump_round(5, 10);
        land(199, 1'b0);
        restart_from_over();

        // async reset in CHARGE
        key = 1'b1;
        repeat (2) tick();
        repeat (5) do_pulse();
        check("charge_state", int'(state), 1);
        check("charge_len", int'(length), 4);
        rst_ni = 1'b0;
        #1 check_reset_outputs("rst_charge");
        key = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (3) tick();

        // async reset in JUMP
        jump_round(3, 6);
        rst_ni = 1'b0;
        #1 check_reset_outputs("rst_jump");
        exp_score = 0;
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (3) tick();

        jump_round(6, 12);
        land(220, 1'b1);

        repeat (10) tick();
        check("queue_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
